// File: rtl/sram22_req_ctrl.sv
// Request/response controller for one sram22 single-port macro: optional post-reset
// zero-fill sweep, then valid/ready requests with read data buffered in an in-order FIFO.
module sram22_req_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 6,
  parameter int WMASK_WIDTH = 32,
  parameter int RSP_DEPTH   = 4,
  parameter int INIT_CLEAR  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [WMASK_WIDTH-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_rdata,
  output logic                   init_done,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [CW-1:0]         DEPTH_C   = CW'(RSP_DEPTH);
  localparam logic [PW-1:0]         PTR_LAST  = PW'(RSP_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    init_done_q, init_done_d;
  logic                    rd_pend_q, rd_pend_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0]   fifo_q [RSP_DEPTH];
  logic [CW:0]             occ_s;
  logic                    accept_s;
  logic                    push_s;
  logic                    pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PTR_LAST) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Occupancy counts buffered entries plus the read still in the macro; pops are not credited.
  assign occ_s     = {1'b0, count_q} + {{CW{1'b0}}, rd_pend_q};
  assign req_ready = (state_q == ST_RUN) && (occ_s < {1'b0, DEPTH_C});
  assign accept_s  = req_valid & req_ready;
  assign push_s    = rd_pend_q;
  assign pop_s     = rsp_ready & (count_q != '0);
  assign rsp_valid = (count_q != '0);
  assign rsp_rdata = fifo_q[rd_ptr_q];
  assign init_done = init_done_q;
  assign rd_pend_d = accept_s & ~req_we;

  // Sweep engine and macro port mux.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    sram_we     = 1'b0;
    sram_wmask  = '0;
    sram_addr   = '0;
    sram_din    = '0;
    case (state_q)
      ST_INIT: begin
        sram_we    = 1'b1;
        sram_wmask = '1;
        sram_addr  = cnt_q;
        if (cnt_q == ADDR_LAST) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      ST_RUN: begin
        if (accept_s) begin
          sram_we    = req_we;
          sram_wmask = req_we ? req_wmask : '0;
          sram_addr  = req_addr;
          sram_din   = req_we ? req_wdata : '0;
        end else begin
          sram_we = 1'b0;
        end
      end
      default: begin
        state_d     = ST_INIT;
        cnt_d       = '0;
        init_done_d = 1'b0;
      end
    endcase
  end

  // Response FIFO pointer and count bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (INIT_CLEAR != 0) begin
        state_q     <= ST_INIT;
        init_done_q <= 1'b0;
      end else begin
        state_q     <= ST_RUN;
        init_done_q <= 1'b1;
      end
      cnt_q     <= '0;
      rd_pend_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q     <= state_d;
      init_done_q <= init_done_d;
      cnt_q       <= cnt_d;
      rd_pend_q   <= rd_pend_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Capture macro read data one cycle after the read was accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RSP_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else if (push_s) begin
      fifo_q[wr_ptr_q] <= sram_dout;
    end else begin
      fifo_q[wr_ptr_q] <= fifo_q[wr_ptr_q];
    end
  end

endmodule
